// File: rtl/mips_pkg.sv
// mips_pkg: shared control-word type, ALUOp encodings and opcode constants for the pipelined MIPS core.
package mips_pkg;
    typedef struct packed {
        logic       reg_dst;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use detector comparing the load in EX against the sources in ID.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_mem_read,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_valid,
    output logic             stall
);
    // $zero never carries a real dependency, so a load targeting it is ignored
    assign stall = ex_mem_read & ex_valid & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt)) & id_valid;
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register inserting bubbles on load-use stalls and flushes.
// Define BUBBLE_CNT_EN to build the saturating stall/flush bubble counters; otherwise they read 0.
module id_ex_stage_reg
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_reg_dst,
    input  logic              id_jump,
    input  logic              id_branch,
    input  logic              id_mem_read,
    input  logic              id_mem_to_reg,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic [1:0]        id_alu_op,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              flush,
    output logic              ex_reg_dst,
    output logic              ex_jump,
    output logic              ex_branch,
    output logic              ex_mem_read,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic [1:0]        ex_alu_op,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic              stall,
    output logic              pc_write,
    output logic              if_id_write,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       flush_cnt
);
    ctrl_t             w_id_ctrl;
    ctrl_t             r_ctrl;
    logic              r_valid;
    logic [DATA_W-1:0] r_pc_plus4, r_rd1, r_rd2, r_imm;
    logic [REG_W-1:0]  r_rs, r_rt, r_rd;
    logic              w_stall;

    assign w_id_ctrl = '{reg_dst: id_reg_dst, jump: id_jump, branch: id_branch,
                         mem_read: id_mem_read, mem_to_reg: id_mem_to_reg,
                         mem_write: id_mem_write, alu_src: id_alu_src,
                         reg_write: id_reg_write, alu_op: id_alu_op};

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .ex_mem_read (r_ctrl.mem_read),
        .ex_valid    (r_valid),
        .ex_rt       (r_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_valid    (id_valid),
        .stall       (w_stall)
    );

    // reset, flush and stall all load the same all-zero bubble
    always_ff @(posedge clk) begin
        if (rst || flush || w_stall) begin
            r_ctrl     <= CTRL_NOP;
            r_valid    <= 1'b0;
            r_pc_plus4 <= '0;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_imm      <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
        end else begin
            r_ctrl     <= w_id_ctrl;
            r_valid    <= id_valid;
            r_pc_plus4 <= id_pc_plus4;
            r_rd1      <= id_rd1;
            r_rd2      <= id_rd2;
            r_imm      <= id_imm;
            r_rs       <= id_rs;
            r_rt       <= id_rt;
            r_rd       <= id_rd;
        end
    end

`ifdef BUBBLE_CNT_EN
    logic [31:0] r_bubble_cnt, r_flush_cnt;

    // flush outranks stall, so a coincident pair counts only as a flush
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (flush) begin
            if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 32'd1;
        end else if (w_stall) begin
            if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`else
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

    assign {ex_reg_dst, ex_jump, ex_branch, ex_mem_read, ex_mem_to_reg,
            ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op} = r_ctrl;
    assign ex_valid    = r_valid;
    assign ex_pc_plus4 = r_pc_plus4;
    assign ex_rd1      = r_rd1;
    assign ex_rd2      = r_rd2;
    assign ex_imm      = r_imm;
    assign ex_rs       = r_rs;
    assign ex_rt       = r_rt;
    assign ex_rd       = r_rd;
    assign stall       = w_stall;
    assign pc_write    = ~w_stall;
    assign if_id_write = ~w_stall;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed plus short random stimulus with a queue scoreboard for id_ex_stage_reg.
module tb_id_ex_stage_reg;
    localparam int VW = 154;
    localparam int RT_L = 5, RT_H = 9, VL = 143, MR = 150;

    logic        clk = 1'b0, rst;
    logic        id_reg_dst, id_jump, id_branch, id_mem_read, id_mem_to_reg;
    logic        id_mem_write, id_alu_src, id_reg_write, id_valid, flush;
    logic [1:0]  id_alu_op;
    logic [31:0] id_pc_plus4, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        ex_reg_dst, ex_jump, ex_branch, ex_mem_read, ex_mem_to_reg;
    logic        ex_mem_write, ex_alu_src, ex_reg_write, ex_valid;
    logic [1:0]  ex_alu_op;
    logic [31:0] ex_pc_plus4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        stall, pc_write, if_id_write;
    logic [31:0] bubble_cnt, flush_cnt;

    int          n_vec = 0, n_err = 0;
    logic [VW-1:0] q[$];
    logic [VW-1:0] m_ex = '0;
    logic        m_known = 1'b0;
    logic [31:0] cb = 0, cf = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .rst(rst),
        .id_reg_dst(id_reg_dst), .id_jump(id_jump), .id_branch(id_branch),
        .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
        .id_valid(id_valid), .id_pc_plus4(id_pc_plus4), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .ex_reg_dst(ex_reg_dst), .ex_jump(ex_jump), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op),
        .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .stall(stall), .pc_write(pc_write), .if_id_write(if_id_write),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    function automatic logic [VW-1:0] id_vec();
        return {id_reg_dst, id_jump, id_branch, id_mem_read, id_mem_to_reg, id_mem_write,
                id_alu_src, id_reg_write, id_alu_op, id_valid, id_pc_plus4, id_rd1, id_rd2,
                id_imm, id_rs, id_rt, id_rd};
    endfunction

    function automatic logic [VW-1:0] ex_vec();
        return {ex_reg_dst, ex_jump, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
                ex_alu_src, ex_reg_write, ex_alu_op, ex_valid, ex_pc_plus4, ex_rd1, ex_rd2,
                ex_imm, ex_rs, ex_rt, ex_rd};
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        {id_reg_dst, id_jump, id_branch, id_mem_read, id_mem_to_reg, id_mem_write,
         id_alu_src, id_reg_write, id_alu_op, id_valid, flush} = '0;
        id_pc_plus4 = 32'h0000_1004; id_rd1 = 32'h1111_0001; id_rd2 = 32'h2222_0002;
        id_imm = 32'hFFFF_FFF0; id_rs = '0; id_rt = '0; id_rd = '0;
    endtask

    task automatic cycle(input string tag);
        logic s;
        logic [VW-1:0] nxt, exp;
        logic [31:0] eb, ef;
        #2;
        s = m_known && m_ex[MR] && m_ex[VL] && (m_ex[RT_H:RT_L] != 5'd0) &&
            ((m_ex[RT_H:RT_L] == id_rs) || (m_ex[RT_H:RT_L] == id_rt)) && id_valid;
        if (m_known) chk({tag, "_stall"}, VW'({stall, pc_write, if_id_write}), VW'({s, ~s, ~s}));
        nxt = (rst || flush || s) ? '0 : id_vec();
        if (rst) begin
            cb = 0; cf = 0;
        end else if (flush) begin
            if (cf != 32'hFFFF_FFFF) cf++;
        end else if (s) begin
            if (cb != 32'hFFFF_FFFF) cb++;
        end
        q.push_back(nxt);
        @(posedge clk);
        #1;
        exp = q.pop_front();
        chk({tag, "_ex"}, ex_vec(), exp);
        m_ex = exp;
        m_known = 1'b1;
`ifdef BUBBLE_CNT_EN
        eb = cb; ef = cf;
`else
        eb = 0; ef = 0;
`endif
        chk({tag, "_cnt"}, VW'({bubble_cnt, flush_cnt}), VW'({eb, ef}));
    endtask

    initial begin
        rst = 1'b1;
        {id_reg_dst, id_jump, id_branch, id_mem_read, id_mem_to_reg, id_mem_write,
         id_alu_src, id_reg_write, id_valid, flush} = '1;
        id_alu_op = 2'b11; id_pc_plus4 = 32'hDEAD_BEEF; id_rd1 = 32'hA5A5_A5A5;
        id_rd2 = 32'h5A5A_5A5A; id_imm = 32'h1234_5678; id_rs = 5'd7; id_rt = 5'd7; id_rd = 5'd3;
        cycle("rst0");
        flush = 1'b0;
        cycle("rst1");
        rst = 1'b0;
        // LW $8, 16($9)
        clr(); id_valid = 1; id_mem_read = 1; id_mem_to_reg = 1; id_alu_src = 1; id_reg_write = 1;
        id_rs = 5'd9; id_rt = 5'd8; id_imm = 32'd16;
        cycle("lw");
        // ADD $11, $8, $10 -> one stall then capture
        clr(); id_valid = 1; id_reg_dst = 1; id_reg_write = 1; id_alu_op = 2'b10;
        id_rs = 5'd8; id_rt = 5'd10; id_rd = 5'd11; id_pc_plus4 = 32'h0000_1008;
        cycle("add_stall");
        cycle("add_go");
        // load to $zero never stalls
        clr(); id_valid = 1; id_mem_read = 1; id_mem_to_reg = 1; id_alu_src = 1; id_reg_write = 1;
        id_rs = 5'd4; id_rt = 5'd0;
        cycle("lw_r0");
        clr(); id_valid = 1; id_reg_dst = 1; id_reg_write = 1; id_alu_op = 2'b10; id_rd = 5'd12;
        cycle("use_r0");
        // BEQ flushed
        clr(); id_valid = 1; id_branch = 1; id_alu_op = 2'b01; id_rs = 5'd1; id_rt = 5'd2; flush = 1;
        cycle("beq_flush");
        // flush coincident with a load-use hazard
        clr(); id_valid = 1; id_mem_read = 1; id_mem_to_reg = 1; id_alu_src = 1; id_reg_write = 1;
        id_rs = 5'd3; id_rt = 5'd8;
        cycle("lw2");
        clr(); id_valid = 1; id_reg_dst = 1; id_reg_write = 1; id_alu_op = 2'b10;
        id_rs = 5'd8; id_rt = 5'd8; id_rd = 5'd13; flush = 1;
        cycle("flush_stall");
        clr(); id_valid = 1; id_mem_write = 1; id_alu_src = 1; id_rs = 5'd8; id_rt = 5'd14;
        id_imm = 32'd4;
        cycle("sw_after");
        // reset arriving during a stall
        clr(); id_valid = 1; id_mem_read = 1; id_mem_to_reg = 1; id_alu_src = 1; id_reg_write = 1;
        id_rs = 5'd2; id_rt = 5'd5;
        cycle("lw3");
        clr(); id_valid = 1; id_reg_dst = 1; id_reg_write = 1; id_alu_op = 2'b10;
        id_rs = 5'd5; id_rt = 5'd6; id_rd = 5'd7; rst = 1;
        cycle("rst_mid");
        rst = 0;
        cycle("post_rst");
        for (int i = 0; i < 24; i++) begin
            {id_reg_dst, id_jump, id_branch, id_mem_to_reg, id_mem_write, id_alu_src,
             id_reg_write, id_alu_op} = 9'($urandom);
            id_mem_read = 1'($urandom);
            id_valid = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 7) == 0);
            id_pc_plus4 = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            id_rd = 5'($urandom);
            cycle("rand");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

Registers the Control unit's decoded signals and ID-stage operands into the ID/EX pipeline boundary of the pipelined MIPS core. Also performs load-use hazard detection: on a hazard it inserts a bubble and freezes PC and IF/ID. The block sits between Control/register-file decode and the EX stage. It also squashes the decoded instruction on a branch/jump flush from later stages.

## Interface
- DATA_W, 32, datapath width
- REG_W, 5, register-address width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_reg_dst, id_jump, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  in  1 each  Control outputs for the instruction in ID
- id_alu_op  in  2  Control ALUOp (00 add, 01 sub, 10 R-type funct)
- id_valid  in  1  ID holds a real instruction
- id_pc_plus4, id_rd1, id_rd2, id_imm  in  DATA_W each  PC+4, register reads, sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_W each  register fields
- flush  in  1  squash ID instruction (taken branch/jump)
- ex_*  out  matching widths  registered copies of every id_* input above, including ex_valid
- stall  out  1  load-use hazard detected this cycle
- pc_write, if_id_write  out  1 each  equal to ~stall
- bubble_cnt, flush_cnt  out  32 each  event counters (see Configuration)

## Operation
- Reset: all ex_* outputs = 0, and both counters = 0. stall is combinational, so it is 0 while ex_mem_read = 0.
- Hazard, combinational: stall = ex_mem_read & ex_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)) & id_valid.
- Each rising edge, priority order:
  - rst: load the zero state.
  - flush: load a bubble. All control bits = 0, alu_op = 00, ex_valid = 0, data/address fields = 0.
  - stall: load a bubble, same as for flush.
  - otherwise: capture all id_* into ex_*.
- Simultaneous flush and stall: flush wins and only flush_cnt increments. stall still drives pc_write/if_id_write low that cycle; upstream flush logic overrides.
- A bubble carries mem_write = reg_write = 0, so it has no architectural effect.
- The bubble clears ex_mem_read, so a stall lasts exactly one cycle per load-use pair.
- Reset mid-stall: the next edge clears state and stall drops immediately.

## Timing
- ID to EX latency: exactly 1 cycle.
- stall, pc_write and if_id_write are combinational from ex_* registers and id_* inputs, valid in the same cycle. There is no registered delay.
- flush is sampled at the edge; the instruction present in ID at that edge never reaches EX.
- Counters update on the same edge as the bubble they count and saturate at 0xFFFF_FFFF (no wrap).

## Configuration
- BUBBLE_CNT_EN defined:
  - bubble_cnt increments on each stall-induced bubble.
  - flush_cnt increments on each flush-induced bubble.
  - Both are 32-bit, saturating, and cleared by rst.
- Undefined: counter registers are not built and both outputs are tied to 0. All other behaviour is identical.

## Structure
- Shared package mips_pkg holds:
  - ctrl_t packed struct with the eight 1-bit controls plus alu_op.
  - CTRL_NOP constant (all zero).
  - ALUOP_ADD/ALUOP_SUB/ALUOP_RTYPE encodings.
  - Opcode constants: R 000000, ADDI 001000, LW 100011, SW 101011, BEQ 000100, J 000010.
- One sub-module, hazard_detect: purely combinational stall equation, instantiated once. Registers and counters stay in the top module.

## Test plan
- Reset: hold rst 2 cycles with all inputs nonzero -> all ex_* = 0, stall = 0, counters = 0.
- LW pass-through: id_mem_read = 1, mem_to_reg = 1, alu_src = 1, reg_write = 1, alu_op = 00, id_rt = 8 -> one cycle later ex_* match exactly, ex_valid = 1.
- Load-use: LW writing rt = 8, then ADD with rs = 8 -> stall = 1 for exactly one cycle, pc_write = 0, and EX gets a bubble. The next cycle the ADD is captured and bubble_cnt = 1 with the macro, 0 without.
- Register-0 immunity: LW with rt = 0 followed by rs = 0 -> stall stays 0.
- Flush: BEQ in ID with flush = 1 -> ex_valid = 0, all controls 0, and flush_cnt increments by 1.
- Flush plus hazard in the same cycle: flush_cnt += 1, bubble_cnt unchanged, and the next edge captures new ID contents normally.
